alu_issue_arb: RTL and testbench

ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

---
 rtl/ooo_pkg.sv | 24 ++
 rtl/alu_issue_arb_if.sv | 36 +++
 rtl/alu_exec.sv | 36 +++
 rtl/alu_issue_arb.sv | 130 +++++++++++++
 tb/tb_alu_issue_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: ALU control encoding, result-stage
// states and default datapath widths.
package ooo_pkg;

  localparam int XLEN_DEF = 32;
  localparam int TAGW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SRA = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/alu_issue_arb_if.sv
// Issue/result bundle between reservation-station ports and the ALU issue
// arbiter. master = requesters + result consumer, slave = the arbiter.
interface alu_issue_arb_if #(
  parameter int NREQ = 4,
  parameter int XLEN = ooo_pkg::XLEN_DEF,
  parameter int TAGW = ooo_pkg::TAGW_DEF
);
  import ooo_pkg::*;

  localparam int SRCW = $clog2(NREQ);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][2:0]      req_op;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;
  logic [NREQ-1:0][TAGW-1:0] req_tag;

  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_value;
  logic [TAGW-1:0] res_tag;
  logic [SRCW-1:0] res_src;
  logic            res_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, res_ready,
    input  req_ready, res_valid, res_value, res_tag, res_src, res_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, res_ready,
    output req_ready, res_valid, res_value, res_tag, res_src, res_zero
  );

endinterface

// File: rtl/alu_exec.sv
// Combinational integer ALU: y = a <op> b modulo 2^XLEN, zero = (y == 0).
// Shift amounts use the low clog2(XLEN) bits of b.
module alu_exec import ooo_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_sh;
  assign w_sh = b[SHW-1:0];

  // operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SRA: y = $signed(a) >>> w_sh;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SRL: y = a >> w_sh;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_issue_arb.sv
// ALU issue arbiter: round-robin grant among NREQ reservation-station ports
// into a single registered result stage (EMPTY/FULL), latency 1.
// Optional feature macro: ALU_ISSUE_PERF_EN adds perf_stall_cnt, a saturating
// count of cycles spent FULL while the result bus is not ready.
module alu_issue_arb import ooo_pkg::*; #(
  parameter int NREQ = 4,
  parameter int XLEN = XLEN_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  alu_issue_arb_if.slave      bus
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int SRCW = $clog2(NREQ);

  res_state_e      r_state, w_state_nxt;
  logic [SRCW-1:0] r_rr_ptr;
  logic [XLEN-1:0] r_res_value;
  logic [TAGW-1:0] r_res_tag;
  logic [SRCW-1:0] r_res_src;
  logic            r_res_zero;

  logic            w_accept;
  logic            w_any;
  logic            w_issue;
  logic [SRCW-1:0] w_gnt_idx;
  logic [XLEN-1:0] w_alu_y;
  logic            w_alu_zero;

  // (base + off) mod NREQ without a divider; off is always < NREQ
  function automatic logic [SRCW-1:0] wrap_idx(input logic [SRCW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return SRCW'(s);
  endfunction

  // round-robin search from r_rr_ptr upward, first valid wins
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && bus.req_valid[wrap_idx(r_rr_ptr, i)]) begin
        w_any     = 1'b1;
        w_gnt_idx = wrap_idx(r_rr_ptr, i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // FSM next state; flush wins over everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_issue ? ST_FULL : ST_EMPTY;
      ST_FULL:  w_state_nxt = (w_issue || !bus.res_ready) ? ST_FULL : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  // FSM outputs: accept window and one-hot grant; reset gates grants immediately
  always_comb begin
    w_accept      = (r_state == ST_EMPTY || bus.res_ready) && !flush && !reset;
    w_issue       = w_accept && w_any;
    bus.req_ready = '0;
    if (w_issue) bus.req_ready[w_gnt_idx] = 1'b1;
  end

  alu_exec #(.XLEN(XLEN)) u_exec (
    .a    (bus.req_a[w_gnt_idx]),
    .b    (bus.req_b[w_gnt_idx]),
    .op   (alu_op_e'(bus.req_op[w_gnt_idx])),
    .y    (w_alu_y),
    .zero (w_alu_zero)
  );

  // round-robin pointer advances only on an actual grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_rr_ptr <= '0;
    else if (w_issue) r_rr_ptr <= wrap_idx(w_gnt_idx, 1);
  end

  // result register: loads on grant, otherwise holds (stable while stalled)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_value <= '0;
      r_res_tag   <= '0;
      r_res_src   <= '0;
      r_res_zero  <= 1'b0;
    end else if (w_issue) begin
      r_res_value <= w_alu_y;
      r_res_tag   <= bus.req_tag[w_gnt_idx];
      r_res_src   <= w_gnt_idx;
      r_res_zero  <= w_alu_zero;
    end
  end

  assign bus.res_valid = (r_state == ST_FULL);
  assign bus.res_value = r_res_value;
  assign bus.res_tag   = r_res_tag;
  assign bus.res_src   = r_res_src;
  assign bus.res_zero  = r_res_zero;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_stall;

  // saturating count of back-pressured cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_perf_stall <= '0;
    else if (r_state == ST_FULL && !bus.res_ready && r_perf_stall != 32'hFFFF_FFFF)
      r_perf_stall <= r_perf_stall + 32'd1;
  end

  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_issue_arb.sv
// Scoreboard bench for alu_issue_arb: directed scenarios plus random traffic
// against a spec-level reference model (round-robin over a list, one-slot
// result buffer, arithmetic ALU reference).
module tb_alu_issue_arb;

  localparam int NREQ = 4;
  localparam int XLEN = 32;
  localparam int TAGW = 5;

  typedef struct {
    logic [31:0] v;
    logic [4:0]  tag;
    logic [1:0]  src;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  alu_issue_arb_if #(.NREQ(NREQ), .XLEN(XLEN), .TAGW(TAGW)) bus ();

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_cnt;
`endif

  alu_issue_arb #(.NREQ(NREQ), .XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_stall_cnt (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  bit   m_full;
  int   m_ptr;
  int   m_stall;

  logic [2:0]  nx_op [NREQ];
  logic [31:0] nx_a  [NREQ];
  logic [31:0] nx_b  [NREQ];
  logic [4:0]  nx_tag[NREQ];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference ALU from the opcode table, plain arithmetic
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      3'd5: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd6: return a >> s;
      default: return a ^ b;
    endcase
  endfunction

  // apply one cycle of stimulus at the negedge, then predict and check grant
  task automatic cycle(input logic [3:0] v, input bit rr, input bit fl, output int g);
    bit   acc;
    exp_t e;
    logic [3:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[i]  = nx_op[i];
      bus.req_a[i]   = nx_a[i];
      bus.req_b[i]   = nx_b[i];
      bus.req_tag[i] = nx_tag[i];
    end
    bus.req_valid = v;
    bus.res_ready = rr;
    flush         = fl;
    #1;
    acc = (!m_full || rr) && !fl;
    g = -1;
    if (acc)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("res_valid", 64'(bus.res_valid), 64'(m_full));
    if (m_full && !rr) m_stall++;
    if (g >= 0) begin
      e.v    = alu_ref(nx_op[g], nx_a[g], nx_b[g]);
      e.tag  = nx_tag[g];
      e.src  = 2'(g);
      e.zero = (e.v == 32'd0);
      sb_q.push_back(e);
      m_ptr = (g + 1) % NREQ;
    end
    m_full = fl ? 1'b0 : ((g >= 0) ? 1'b1 : (m_full && !rr));
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_ptr   = 0;
    m_stall = 0;
    sb_q.delete();
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      nx_op[i]  = 3'($urandom_range(0, 7));
      nx_a[i]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      nx_b[i]   = ($urandom_range(0, 7) == 0) ? nx_a[i] : $urandom;
      nx_tag[i] = 5'($urandom_range(0, 31));
    end
  endtask

  // monitor: compare the held result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) continue;
      if (bus.res_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_unexpected: got res_valid=1 expected no pending result at %0t", $time);
        end else if (flush) begin
          void'(sb_q.pop_front());
        end else begin
          e = sb_q[0];
          chk("res_value", 64'(bus.res_value), 64'(e.v));
          chk("res_tag",   64'(bus.res_tag),   64'(e.tag));
          chk("res_src",   64'(bus.res_src),   64'(e.src));
          chk("res_zero",  64'(bus.res_zero),  64'(e.zero));
          if (bus.res_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    logic [2:0]  d_op [3];
    logic [31:0] d_a  [3];
    logic [31:0] d_b  [3];
    logic [31:0] d_y  [3];
    d_op = '{3'b100, 3'b110, 3'b101};
    d_a  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    d_b  = '{32'd4, 32'd4, 32'd1};
    d_y  = '{32'hF800_0000, 32'h0800_0000, 32'd1};

    for (int i = 0; i < NREQ; i++) begin
      nx_op[i] = '0; nx_a[i] = '0; nx_b[i] = '0; nx_tag[i] = '0;
      bus.req_op[i] = '0; bus.req_a[i] = '0; bus.req_b[i] = '0; bus.req_tag[i] = '0;
    end
    reset = 1'b1;
    flush = 1'b0;
    bus.req_valid = 4'hF;
    bus.res_ready = 1'b1;
    model_reset();
    #1;
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_value", 64'(bus.res_value), 64'd0);
    chk("rst_res_tag",   64'(bus.res_tag),   64'd0);
    chk("rst_res_src",   64'(bus.res_src),   64'd0);
    chk("rst_res_zero",  64'(bus.res_zero),  64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 4'h0;
    #1 reset = 1'b0;

    // all four requesting: strict rotation 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      cycle(4'hF, 1'b1, 1'b0, g);
      chk("rr_order", 64'(g), 64'(k % NREQ));
    end

    // sub on requester 1
    nx_op[1] = 3'b001; nx_a[1] = 32'd5; nx_b[1] = 32'd7; nx_tag[1] = 5'd9;
    cycle(4'b0010, 1'b1, 1'b0, g);
    chk("sub_gnt", 64'(g), 64'd1);
    cycle(4'b0000, 1'b1, 1'b0, g);
    chk("sub_value", 64'(bus.res_value), 64'h0000_0000_FFFF_FFFE);
    chk("sub_tag",   64'(bus.res_tag),   64'd9);
    chk("sub_src",   64'(bus.res_src),   64'd1);
    chk("sub_zero",  64'(bus.res_zero),  64'd0);

    // shifts and signed compare on requester 0
    for (int k = 0; k < 3; k++) begin
      nx_op[0] = d_op[k]; nx_a[0] = d_a[k]; nx_b[0] = d_b[k]; nx_tag[0] = 5'(k);
      cycle(4'b0001, 1'b1, 1'b0, g);
      cycle(4'b0000, 1'b1, 1'b0, g);
      chk("shift_slt_value", 64'(bus.res_value), 64'(d_y[k]));
    end

    // back-pressure for 3 cycles, then release grants in the same cycle
    rand_fields();
    cycle(4'hF, 1'b1, 1'b0, g);
    for (int k = 0; k < 3; k++) cycle(4'hF, 1'b0, 1'b0, g);
    cycle(4'hF, 1'b1, 1'b0, g);
    chk("stall_release_gnt", 64'(g >= 0), 64'd1);

    // flush while FULL and being consumed: no grant, empty next cycle
    cycle(4'b0100, 1'b1, 1'b1, g);
    chk("flush_no_gnt", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
    cycle(4'b0000, 1'b1, 1'b0, g);
    chk("flush_empty", 64'(bus.res_valid), 64'd0);
    cycle(4'hF, 1'b1, 1'b0, g);

    // asynchronous reset mid-cycle while FULL
    cycle(4'hF, 1'b0, 1'b0, g);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.res_valid), 64'd0);
    chk("async_rst_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 4'h0;
    model_reset();
    reset = 1'b0;
    rand_fields();
    cycle(4'hF, 1'b1, 1'b0, g);
    chk("post_rst_gnt", 64'(g), 64'd0);
    for (int k = 0; k < 5; k++) cycle(4'h0, 1'b0, 1'b0, g);
    cycle(4'h0, 1'b1, 1'b0, g);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_5_stalls", 64'(perf_cnt), 64'd5);
`endif

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rand_fields();
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), g);
    end
    cycle(4'h0, 1'b1, 1'b0, g);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_total", 64'(perf_cnt), 64'(m_stall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
